// File: rtl/uart_response_tx.sv
// Two-byte UART response transmitter: command byte then value byte, back to back.
// Define UART_PARITY_EN to add an even-parity bit to each byte (8E1); otherwise 8N1.
module uart_response_tx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       send_request,
  input  logic [7:0] command_byte,
  input  logic [7:0] value_byte,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  // state  | meaning
  // IDLE   | line high, waiting for a send_request rising edge
  // START  | start bit (0) of the current byte
  // DATA   | data bits, LSB first, bit_idx_q selects the bit
  // PARITY | even parity of the current byte (UART_PARITY_EN builds only)
  // STOP   | stop bit (1); after byte 1 the transfer ends

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             byte_idx_q, byte_idx_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       val_q, val_d;
  logic             tx_q, tx_d;
  logic             req_prev_q;
  logic             req_rise;
  logic             bit_end;
  logic [7:0]       cur_byte_d;

  assign req_rise = send_request & ~req_prev_q;
  assign bit_end  = (cnt_q == CNT_LAST);

  // History resets high so a request already asserted at reset release is not an edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= 1'b0;
      cmd_q      <= 8'h00;
      val_q      <= 8'h00;
      tx_q       <= 1'b1;
      req_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      cmd_q      <= cmd_d;
      val_q      <= val_d;
      tx_q       <= tx_d;
      req_prev_q <= send_request;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    cmd_d      = cmd_q;
    val_d      = val_q;

    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (req_rise) begin
          cmd_d      = command_byte;
          val_d      = value_byte;
          byte_idx_d = 1'b0;
          bit_idx_d  = '0;
          cnt_d      = '0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (!byte_idx_q) begin
            byte_idx_d = 1'b1;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the next state so the line never glitches.
    cur_byte_d = byte_idx_d ? val_d : cmd_d;
    unique case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte_d[bit_idx_d];
`ifdef UART_PARITY_EN
      PARITY:  tx_d = ^cur_byte_d;
`endif
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == STOP) && byte_idx_q && bit_end;

endmodule

// File: tb/tb_uart_response_tx.sv
// Scoreboard bench for uart_response_tx: accepted requests are queued by the driver,
// a negedge monitor checks tx/busy/done every cycle and the decoded bytes on done.
module tb_uart_response_tx;

  localparam int CPB = 10;
`ifdef UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FB  = 10 + PAR;
  localparam int LEN = 2 * FB * CPB;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] val;
    longint     start;
  } xfer_t;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       send_request;
  logic [7:0] command_byte;
  logic [7:0] value_byte;
  logic       tx, busy, done;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint model_end = -1;
  logic   model_prev = 1'b1;
  xfer_t  q[$];

  xfer_t  cur;
  bit     have_cur = 0;
  logic   rx_bits [0:2*FB-1];

  uart_response_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000)) dut (
    .clock(clock), .reset_n(reset_n), .send_request(send_request),
    .command_byte(command_byte), .value_byte(value_byte),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;
  // Level of send_request as seen by the design in the previous cycle.
  always @(posedge clock) model_prev = reset_n ? send_request : 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] c, input logic [7:0] v, input int i);
    int k;
    int j;
    logic [7:0] b;
    k = i / FB;
    j = i % FB;
    b = (k != 0) ? v : c;
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (PAR == 1 && j == 9) return ^b;
    return 1'b1;
  endfunction

  function automatic logic [7:0] pick();
    int r;
    r = $urandom_range(0, 7);
    case (r)
      0: return 8'h45;
      1: return 8'hFF;
      2: return 8'hAB;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drive the request level and bytes; queue a transfer when the design should accept it.
  task automatic set_req(input logic v, input logic [7:0] c, input logic [7:0] b);
    command_byte = c;
    value_byte   = b;
    send_request = v;
    if (reset_n && v && !model_prev && cyc > model_end) begin
      q.push_back('{cmd: c, val: b, start: cyc + 1});
      model_end = cyc + LEN;
    end
  endtask

  task automatic do_reset(input int n);
    reset_n    = 1'b0;
    model_prev = 1'b1;
    model_end  = -1;
    q.delete();
    repeat (n) step();
    reset_n = 1'b1;
  endtask

  task automatic wait_idle();
    while (cyc <= model_end) step();
  endtask

  always @(negedge clock) begin
    logic   etx, ebusy, edone;
    longint off;
    logic [7:0] rc, rv;
    etx = 1'b1; ebusy = 1'b0; edone = 1'b0; off = 0;
    if (!reset_n) begin
      have_cur = 0;
    end else begin
      if (!have_cur && q.size() > 0 && q[0].start == cyc) begin
        cur = q.pop_front();
        have_cur = 1;
      end
      if (have_cur && cyc >= cur.start && cyc <= cur.start + LEN - 1) begin
        off   = cyc - cur.start;
        etx   = exp_bit(cur.cmd, cur.val, int'(off / CPB));
        ebusy = 1'b1;
        edone = (cyc == cur.start + LEN - 1);
        if (off % CPB == CPB / 2) rx_bits[int'(off / CPB)] = tx;
      end
    end
    chk("tx", tx, etx);
    chk("busy", busy, ebusy);
    chk("done", done, edone);
    if (done === 1'b1 && have_cur) begin
      for (int i = 0; i < 8; i++) begin
        rc[i] = rx_bits[1 + i];
        rv[i] = rx_bits[FB + 1 + i];
      end
      chk("cmd_payload", rc, cur.cmd);
      chk("val_payload", rv, cur.val);
    end
    if (edone) have_cur = 0;
  end

  initial begin
    longint n0, e0;
    int     r;
    reset_n = 1'b0; send_request = 1'b0; command_byte = 8'h00; value_byte = 8'h00;
    do_reset(4);
    repeat (3) step();

    // Reference frame 0x09 / 0x1A
    set_req(1'b1, 8'h09, 8'h1A);
    repeat (5) step();
    set_req(1'b0, 8'h00, 8'h00);
    wait_idle();
    repeat (3) step();

    // Parity-bearing pattern 0x07 / 0x07
    set_req(1'b1, 8'h07, 8'h07);
    step(); set_req(1'b0, 8'h07, 8'h07);
    wait_idle();
    repeat (2) step();

    // Second edge mid-transfer with changed bytes must be ignored
    set_req(1'b1, 8'h3C, 8'hC3);
    repeat (20) step(); set_req(1'b0, 8'h3C, 8'hC3);
    repeat (30) step(); set_req(1'b1, 8'hFF, 8'hFF);
    repeat (10) step(); set_req(1'b0, 8'hFF, 8'hFF);
    wait_idle();
    repeat (2) step();

    // Request held high through reset release
    send_request = 1'b1;
    do_reset(3);
    repeat (300) step();
    set_req(1'b0, 8'hAB, 8'h5A);
    step(); set_req(1'b1, 8'hAB, 8'h5A);
    step(); set_req(1'b0, 8'hAB, 8'h5A);
    wait_idle();
    repeat (2) step();

    // Reset in the middle of a frame, then a clean transfer
    set_req(1'b1, 8'hA5, 8'h96);
    n0 = cyc;
    step(); set_req(1'b0, 8'hA5, 8'h96);
    while (cyc < n0 + 75) step();
    do_reset(3);
    repeat (4) step();
    set_req(1'b1, 8'h81, 8'h7E);
    step(); set_req(1'b0, 8'h81, 8'h7E);
    wait_idle();
    repeat (2) step();

    // Edge in the cycle right after done
    set_req(1'b1, 8'h45, 8'h45);
    e0 = model_end;
    step(); set_req(1'b0, 8'h45, 8'h45);
    while (cyc < e0 + 1) step();
    set_req(1'b1, 8'h45, 8'h45);
    step(); set_req(1'b0, 8'h45, 8'h45);
    wait_idle();
    repeat (2) step();

    // Random request toggling and byte churn
    for (int i = 0; i < 3000; i++) begin
      step();
      r = $urandom_range(0, 99);
      if (r < 4) set_req(~send_request, pick(), pick());
      else if (r < 12) set_req(send_request, pick(), pick());
    end
    set_req(1'b0, 8'h00, 8'h00);
    wait_idle();
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    errors++;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
